// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Front end for the game controller's key[7:0] input. Each of the eight raw
//   push-button lines is synchronised and debounced. A session FSM then turns
//   each press session into exactly one stretched one-hot event. If more than
//   one key is already down when the session starts, it produces a key_multi
//   pulse instead of an event.
//
//   Ports
//     clk        system clock
//     nrst       asynchronous active-low reset
//     key_raw    raw, asynchronous, bouncing button lines
//     key_level  debounced level per key, 1 = held
//     key_press  1-cycle pulse per key on a debounced 0->1 transition
//     key_out    one-hot event, held HOLD_CYC cycles, 0 when idle
//     key_idx    binary index of the set bit of key_out, 0 when key_out == 0
//     key_multi  1-cycle pulse: the session started with more than one key down
//     any_down   OR of key_level
//
//   Event FSM states
//     state       | meaning
//     ST_IDLE     | no session open, waiting for a debounced press
//     ST_HOLD     | key_out asserted, hold_cnt counting down to 0
//     ST_WAIT_REL | session closed for new events until every key is released
module key_input_conditioner #(
  parameter int FRQ            = 1_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int HOLD_CYC       = 4,
  parameter int KEY_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] key_raw,
  output logic [7:0] key_level,
  output logic [7:0] key_press,
  output logic [7:0] key_out,
  output logic [2:0] key_idx,
  output logic       key_multi,
  output logic       any_down
);

  localparam int DEB_RAW = (FRQ / 1000) * DEBOUNCE_MS;
  localparam int DEB_CYC = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int CNT_W   = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
  localparam int HOLD_W  = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT_REL} state_t;

  logic [7:0] key_in;
  logic [7:0] sync_a, sync_b;

  // Polarity is normalised ahead of the synchroniser so that 1 always means pressed.
  assign key_in = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= key_in;
      sync_b <= sync_a;
    end
  end

  // A new level is accepted only after DEB_CYC consecutive samples that differ from the
  // current level. Any agreeing sample clears the count, so the counter never wraps.
  for (genvar i = 0; i < 8; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             prs;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
      end else begin
        prs <= 1'b0;
        if (sync_b[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          lvl <= sync_b[i];
          prs <= sync_b[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign key_level[i] = lvl;
    assign key_press[i] = prs;
  end

  assign any_down = |key_level;

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [7:0]         out_nxt;
  logic [2:0]         idx_nxt;
  logic               multi_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      key_out   <= '0;
      key_idx   <= '0;
      key_multi <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      key_out   <= out_nxt;
      key_idx   <= idx_nxt;
      key_multi <= multi_nxt;
    end
  end

  // The FSM reads the registered key_level/key_press. An event therefore lands one cycle
  // after the key_press pulse, and key_out is a clean register output.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    out_nxt   = key_out;
    idx_nxt   = key_idx;
    multi_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_press != 8'h00) begin
          if ($countones(key_level) == 1) begin
            out_nxt   = key_level;
            idx_nxt   = onehot_idx(key_level);
            hold_nxt  = HOLD_LAST;
            state_nxt = ST_HOLD;
          end else if ($countones(key_level) > 1) begin
            multi_nxt = 1'b1;
            state_nxt = ST_WAIT_REL;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          out_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = ST_WAIT_REL;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (key_level == 8'h00) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
